// File: rtl/fetcher_pkg.sv
// Shared constants for the instruction fetch stage:
// FSM encodings, cache geometry and common literals.
package fetcher_pkg;

    localparam int InstrLength      = 32;
    localparam int PcLength         = 32;
    localparam int ICacheIndexWidth = 6;

    localparam logic [1:0] FetchIdle  = 2'd0;
    localparam logic [1:0] FetchMiss  = 2'd1;
    localparam logic [1:0] FetchOut   = 2'd2;
    localparam logic [1:0] FetchDrain = 2'd3;

    localparam logic [31:0] Zero  = 32'h0;
    localparam logic        True  = 1'b1;
    localparam logic        False = 1'b0;

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache, one word per line.
// Combinational read, synchronous fill; only rst clears valid bits.
module icache
    import fetcher_pkg::*;
#(
    parameter int IndexWidth = ICacheIndexWidth,
    parameter int TagWidth   = 30 - ICacheIndexWidth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IndexWidth-1:0]  rd_index,
    input  logic [TagWidth-1:0]    rd_tag,
    output logic                   hit,
    output logic [InstrLength-1:0] data,
    input  logic                   wr_en,
    input  logic [IndexWidth-1:0]  wr_index,
    input  logic [TagWidth-1:0]    wr_tag,
    input  logic [InstrLength-1:0] wr_data
);

    localparam int Entries = 1 << IndexWidth;

    logic [Entries-1:0]     valid_q;
    logic [TagWidth-1:0]    tag_q  [Entries];
    logic [InstrLength-1:0] data_q [Entries];

    assign hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    assign data = data_q[rd_index];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= True;
        end
    end

    // Tag and data need no reset; valid gates every use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: icache lookup on the queue tail PC,
// memory refill on miss, one-cycle delivery pulse to the queue.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int ICacheIndexWidth = fetcher_pkg::ICacheIndexWidth,
    parameter int TagWidth         = 30 - ICacheIndexWidth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PcLength-1:0]    pc_from_iq,
    input  logic                   is_full_from_iq,
    input  logic                   is_exception_from_rob,
    output logic                   is_hit_to_iq,
    output logic [InstrLength-1:0] instr_to_iq,
    output logic                   is_req_to_mc,
    output logic [PcLength-1:0]    addr_to_mc,
    input  logic                   is_ack_from_mc,
    input  logic [InstrLength-1:0] data_from_mc
);

    logic [1:0]                  state;
    logic [PcLength-1:2]         miss_pc;
    logic                        c_hit;
    logic [InstrLength-1:0]      c_data;
    logic                        fill;
    logic                        unused_pc_bits;

    assign unused_pc_bits = ^pc_from_iq[1:0];
    assign addr_to_mc     = {miss_pc, 2'b00};
    assign fill = is_ack_from_mc &&
                  ((state == FetchMiss) || (state == FetchDrain));

    icache #(
        .IndexWidth (ICacheIndexWidth),
        .TagWidth   (TagWidth)
    ) u_icache (
        .clk      (clk),
        .rst      (rst),
        .rd_index (pc_from_iq[ICacheIndexWidth+1:2]),
        .rd_tag   (pc_from_iq[31:ICacheIndexWidth+2]),
        .hit      (c_hit),
        .data     (c_data),
        .wr_en    (fill),
        .wr_index (miss_pc[ICacheIndexWidth+1:2]),
        .wr_tag   (miss_pc[31:ICacheIndexWidth+2]),
        .wr_data  (data_from_mc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FetchIdle;
            miss_pc      <= '0;
            is_hit_to_iq <= False;
            instr_to_iq  <= Zero;
            is_req_to_mc <= False;
        end else begin
            is_hit_to_iq <= False;
            unique case (state)
                FetchIdle: begin
                    if (!is_exception_from_rob && !is_full_from_iq) begin
                        if (c_hit) begin
                            instr_to_iq  <= c_data;
                            is_hit_to_iq <= True;
                            state        <= FetchOut;
                        end else begin
                            miss_pc      <= pc_from_iq[31:2];
                            is_req_to_mc <= True;
                            state        <= FetchMiss;
                        end
                    end
                end
                FetchMiss: begin
                    if (is_ack_from_mc) begin
                        is_req_to_mc <= False;
                        if (is_exception_from_rob) begin
                            state <= FetchIdle;
                        end else begin
                            instr_to_iq  <= data_from_mc;
                            is_hit_to_iq <= True;
                            state        <= FetchOut;
                        end
                    end else if (is_exception_from_rob) begin
                        // Request must still complete; just discard it.
                        state <= FetchDrain;
                    end
                end
                FetchOut: begin
                    state <= FetchIdle;
                end
                FetchDrain: begin
                    if (is_ack_from_mc) begin
                        is_req_to_mc <= False;
                        state        <= FetchIdle;
                    end
                end
                default: state <= FetchIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: memory responder plus
// scoreboard queues for delivered instructions and request addresses.
module tb_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_from_iq = '0;
    logic        is_full_from_iq = 1'b1;
    logic        is_exception_from_rob = 1'b0;
    logic        is_hit_to_iq;
    logic [31:0] instr_to_iq;
    logic        is_req_to_mc;
    logic [31:0] addr_to_mc;
    logic        is_ack_from_mc = 1'b0;
    logic [31:0] data_from_mc = '0;

    int n_cmp = 0;
    int n_err = 0;
    int ack_delay = 3;
    int ack_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];

    fetcher dut (
        .clk                   (clk),
        .rst                   (rst),
        .pc_from_iq            (pc_from_iq),
        .is_full_from_iq       (is_full_from_iq),
        .is_exception_from_rob (is_exception_from_rob),
        .is_hit_to_iq          (is_hit_to_iq),
        .instr_to_iq           (instr_to_iq),
        .is_req_to_mc          (is_req_to_mc),
        .addr_to_mc            (addr_to_mc),
        .is_ack_from_mc        (is_ack_from_mc),
        .data_from_mc          (data_from_mc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0513;
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Memory controller model: ack after ack_delay request cycles.
    initial begin
        forever begin
            @(negedge clk);
            is_ack_from_mc = 1'b0;
            if (rst || !is_req_to_mc) begin
                ack_cnt = 0;
            end else begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) begin
                    if (addr_q.size() == 0)
                        chk("spurious_req", {31'b0, is_req_to_mc}, 32'h0);
                    else
                        chk("req_addr", addr_to_mc, addr_q.pop_front());
                    data_from_mc   = mem_of(addr_to_mc);
                    is_ack_from_mc = 1'b1;
                    ack_cnt        = 0;
                end
            end
        end
    end

    // Delivery monitor.
    always @(negedge clk) begin
        if (!rst && is_hit_to_iq) begin
            if (exp_q.size() == 0)
                chk("spurious_hit", {31'b0, is_hit_to_iq}, 32'h0);
            else
                chk("instr", instr_to_iq, exp_q.pop_front());
        end
    end

    task automatic fetch(input string tag, input logic [31:0] pc,
                         input bit miss);
        int  n;
        bit  saw_req;
        bit  got;
        @(posedge clk); #1;
        pc_from_iq            = pc;
        is_full_from_iq       = 1'b0;
        is_exception_from_rob = 1'b0;
        exp_q.push_back(mem_of(pc));
        if (miss) addr_q.push_back({pc[31:2], 2'b00});
        n = 0;
        saw_req = 1'b0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk); #1;
            n++;
            if (is_req_to_mc) saw_req = 1'b1;
            if (is_hit_to_iq) got = 1'b1;
        end
        is_full_from_iq = 1'b1;
        chk({tag, "_pulse"}, {31'b0, got}, 32'h1);
        chk({tag, "_lat"}, n, miss ? ack_delay + 1 : 1);
        chk({tag, "_req"}, {31'b0, saw_req}, {31'b0, miss});
    endtask

    initial begin
        int n;
        #1;
        chk("rst_hit", {31'b0, is_hit_to_iq}, 32'h0);
        chk("rst_instr", instr_to_iq, 32'h0);
        chk("rst_req", {31'b0, is_req_to_mc}, 32'h0);
        chk("rst_addr", addr_to_mc, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        ack_delay = 3;
        fetch("cold", 32'h0, 1'b1);
        fetch("warm", 32'h0, 1'b0);
        fetch("conf", 32'h100, 1'b1);
        fetch("evict", 32'h0, 1'b1);
        fetch("rehit", 32'h0, 1'b0);

        // Backpressure at a missing PC.
        @(posedge clk); #1;
        pc_from_iq = 32'h200;
        is_full_from_iq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_req", {31'b0, is_req_to_mc}, 32'h0);
        end
        ack_delay = 2;
        fetch("bp_rel", 32'h200, 1'b1);

        // Exception while the miss is outstanding.
        ack_delay = 4;
        @(posedge clk); #1;
        pc_from_iq = 32'h300;
        is_full_from_iq = 1'b0;
        addr_q.push_back(32'h300);
        @(posedge clk); #1;
        is_full_from_iq = 1'b1;
        chk("exc_req", {31'b0, is_req_to_mc}, 32'h1);
        @(posedge clk); #1;
        is_exception_from_rob = 1'b1;
        @(posedge clk); #1;
        is_exception_from_rob = 1'b0;
        pc_from_iq = 32'h40;
        n = 0;
        while (n < 20 && is_req_to_mc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("exc_drained", {31'b0, is_req_to_mc}, 32'h0);
        repeat (2) @(posedge clk);
        ack_delay = 3;
        fetch("after_exc", 32'h40, 1'b1);
        fetch("exc_filled", 32'h300, 1'b0);

        // Reset with a request outstanding.
        ack_delay = 10;
        @(posedge clk); #1;
        pc_from_iq = 32'h500;
        is_full_from_iq = 1'b0;
        @(posedge clk); #1;
        is_full_from_iq = 1'b1;
        @(posedge clk); #3;
        chk("pre_rst_req", {31'b0, is_req_to_mc}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, is_req_to_mc}, 32'h0);
        chk("mid_rst_hit", {31'b0, is_hit_to_iq}, 32'h0);
        chk("mid_rst_addr", addr_to_mc, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        ack_delay = 2;
        fetch("post_rst", 32'h0, 1'b1);
        fetch("post_rst_hit", 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        chk("exp_left", exp_q.size(), 32'h0);
        chk("addr_left", addr_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
